// File: rtl/seq_writeback_stage_if.sv
//------------------------------------------------------------------------------
// seq_writeback_stage_if
// Data-memory read channel between the writeback stage and data memory.
//   mem_read_req   stage -> memory  read request, held until ready or abort
//   mem_address    stage -> memory  read address, stable while request is high
//   mem_read_data  memory -> stage  read data, valid while mem_ready is high
//   mem_ready      memory -> stage  read completion
// Modports: master = writeback stage, slave = memory.
//------------------------------------------------------------------------------
interface seq_writeback_stage_if #(
   parameter int ADDRESS_SIZE = 10,
   parameter int DATA_SIZE    = 32
);
   logic                    mem_read_req;
   logic [ADDRESS_SIZE-1:0] mem_address;
   logic [DATA_SIZE-1:0]    mem_read_data;
   logic                    mem_ready;

   modport master (
      output mem_read_req,
      output mem_address,
      input  mem_read_data,
      input  mem_ready
   );

   modport slave (
      input  mem_read_req,
      input  mem_address,
      output mem_read_data,
      output mem_ready
   );
endinterface

// File: rtl/seq_writeback_stage.sv
//------------------------------------------------------------------------------
// seq_writeback_stage
// Consumer end of the EXECUTE stage register. Commits ALU results to an
// 8-entry register file in one cycle; loads issue a req/ready memory read,
// stall upstream until data returns, and abort after TIMEOUT_CYCLES cycles.
// Two read ports with write bypass serve DECODE.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_sys_halt                   blocks acceptance while idle
//   i_instruction, i_data_source,
//   i_destination, i_result,
//   i_register_file_write        execute-stage register outputs
//   mem_bus (master)             data-memory read channel
//   o_wb_stall                   high while a load is outstanding
//   i_read_addr_a/_b,
//   o_read_data_a/_b             bypassed register-file read ports
//   o_retire_valid,
//   o_retired_instruction        one-cycle pulse / instruction of last commit
//   o_load_error                 sticky load-timeout flag
//------------------------------------------------------------------------------
module seq_writeback_stage #(
   parameter int ADDRESS_SIZE   = 10,
   parameter int DATA_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_sys_halt,
   input  logic [15:0]          i_instruction,
   input  logic                 i_data_source,
   input  logic [2:0]           i_destination,
   input  logic [DATA_SIZE-1:0] i_result,
   input  logic                 i_register_file_write,
   seq_writeback_stage_if.master mem_bus,
   output logic                 o_wb_stall,
   input  logic [2:0]           i_read_addr_a,
   input  logic [2:0]           i_read_addr_b,
   output logic [DATA_SIZE-1:0] o_read_data_a,
   output logic [DATA_SIZE-1:0] o_read_data_b,
   output logic                 o_retire_valid,
   output logic [15:0]          o_retired_instruction,
   output logic                 o_load_error
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);

   typedef enum logic [0:0] {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [CW-1:0]           r_counter;
   logic [CW-1:0]           w_counter_next;
   logic [2:0]              r_dest;
   logic [15:0]             r_load_instr;
   logic [ADDRESS_SIZE-1:0] r_mem_address;
   logic                    r_mem_read_req;
   logic                    r_wb_stall;
   logic                    r_retire_valid;
   logic [15:0]             r_retired_instruction;
   logic                    r_load_error;
   logic [DATA_SIZE-1:0]    r_regs [8];

   logic                    w_commit_en;
   logic [2:0]              w_commit_idx;
   logic [DATA_SIZE-1:0]    w_commit_data;
   logic [15:0]             w_commit_instr;
   logic                    w_load_start;
   logic                    w_load_abort;
   logic                    w_unused_addr_bits;

   // Upper result bits are not part of the memory address.
   assign w_unused_addr_bits = ^i_result[DATA_SIZE-1:ADDRESS_SIZE];

   // Next-state and commit decode; pipeline inputs only matter in IDLE.
   always_comb begin
      w_next_state   = r_state;
      w_counter_next = r_counter;
      w_commit_en    = 1'b0;
      w_commit_idx   = r_dest;
      w_commit_data  = mem_bus.mem_read_data;
      w_commit_instr = r_load_instr;
      w_load_start   = 1'b0;
      w_load_abort   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_register_file_write && !i_sys_halt) begin
               if (!i_data_source) begin
                  w_commit_en    = 1'b1;
                  w_commit_idx   = i_destination;
                  w_commit_data  = i_result;
                  w_commit_instr = i_instruction;
               end else begin
                  w_load_start   = 1'b1;
                  w_counter_next = {CW{1'b0}};
                  w_next_state   = ST_LOAD_WAIT;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_LOAD_WAIT: begin
            // Ready wins over a timeout landing in the same cycle.
            if (mem_bus.mem_ready) begin
               w_commit_en  = 1'b1;
               w_next_state = ST_IDLE;
            end else if (r_counter == LP_CNT_LAST) begin
               w_load_abort = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_counter_next = r_counter + LP_CNT_ONE;
            end
         end
         default: begin
            w_next_state   = ST_IDLE;
            w_counter_next = {CW{1'b0}};
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Load bookkeeping: timeout counter, latched destination/instruction, request.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_counter      <= {CW{1'b0}};
         r_dest         <= 3'd0;
         r_load_instr   <= 16'h0000;
         r_mem_address  <= {ADDRESS_SIZE{1'b0}};
         r_mem_read_req <= 1'b0;
         r_wb_stall     <= 1'b0;
      end else begin
         r_counter      <= w_counter_next;
         r_mem_read_req <= (w_next_state == ST_LOAD_WAIT);
         r_wb_stall     <= (w_next_state == ST_LOAD_WAIT);
         if (w_load_start) begin
            r_dest        <= i_destination;
            r_load_instr  <= i_instruction;
            r_mem_address <= i_result[ADDRESS_SIZE-1:0];
         end
      end
   end

   // Register file; all eight entries are writable.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= {DATA_SIZE{1'b0}};
         end
      end else if (w_commit_en) begin
         r_regs[w_commit_idx] <= w_commit_data;
      end
   end

   // Retire pulse and instruction of the most recent commit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_retire_valid        <= 1'b0;
         r_retired_instruction <= 16'h0000;
      end else begin
         r_retire_valid <= w_commit_en;
         if (w_commit_en) begin
            r_retired_instruction <= w_commit_instr;
         end
      end
   end

   // Sticky load-timeout flag, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_load_error <= 1'b0;
      end else if (w_load_abort) begin
         r_load_error <= 1'b1;
      end
   end

   // Read ports forward the data being committed this cycle to the same index.
   always_comb begin
      o_read_data_a = r_regs[i_read_addr_a];
      o_read_data_b = r_regs[i_read_addr_b];
      if (w_commit_en && (w_commit_idx == i_read_addr_a)) begin
         o_read_data_a = w_commit_data;
      end else begin
         o_read_data_a = r_regs[i_read_addr_a];
      end
      if (w_commit_en && (w_commit_idx == i_read_addr_b)) begin
         o_read_data_b = w_commit_data;
      end else begin
         o_read_data_b = r_regs[i_read_addr_b];
      end
   end

   assign mem_bus.mem_read_req  = r_mem_read_req;
   assign mem_bus.mem_address   = r_mem_address;
   assign o_wb_stall            = r_wb_stall;
   assign o_retire_valid        = r_retire_valid;
   assign o_retired_instruction = r_retired_instruction;
   assign o_load_error          = r_load_error;

endmodule
